pipelined_core_param: RTL and testbench

//  Parametrised 4-stage (IF, ID, EX, WB) in-order integer core; successor of the fixed 4-register pipeline.

---
 rtl/pipelined_core_param_pkg.sv | 39 +++
 rtl/pipelined_core_param_if.sv | 32 +++
 rtl/pipelined_core_param_regfile.sv | 33 +++
 rtl/pipelined_core_param.sv | 132 +++++++++++++
 tb/tb_pipelined_core_param.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_core_param_pkg.sv
// Shared opcodes and instruction-format helpers for the parametrised 4-stage core.
// Format is [opc 3][rd RA][rs RA][rt RA]; fields are extracted from a 32-bit view of the word.
package pp_pkg;

  localparam logic [2:0] OPC_NOP  = 3'b000;
  localparam logic [2:0] OPC_ADD  = 3'b001;
  localparam logic [2:0] OPC_SUB  = 3'b010;
  localparam logic [2:0] OPC_AND  = 3'b011;
  localparam logic [2:0] OPC_OR   = 3'b100;
  localparam logic [2:0] OPC_XOR  = 3'b101;
  localparam logic [2:0] OPC_LDI  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  function automatic int calc_ra(input int n);
    return $clog2(n);
  endfunction

  function automatic int calc_instr_w(input int ra);
    return 32'sd3 + 32'sd3 * ra;
  endfunction

  function automatic logic [2:0] get_opc(input logic [31:0] instr, input int ra);
    return 3'(instr >> (32'sd3 * ra));
  endfunction

  // pos selects the field: 0 = rt, 1 = rs, 2 = rd
  function automatic logic [31:0] get_field(input logic [31:0] instr, input int ra, input int pos);
    return (instr >> (pos * ra)) & ((32'd1 << ra) - 32'd1);
  endfunction

  function automatic logic [31:0] get_imm(input logic [31:0] instr, input int ra);
    return instr & ((32'd1 << (32'sd2 * ra)) - 32'd1);
  endfunction

  function automatic logic is_writer(input logic [2:0] opc);
    return (opc >= OPC_ADD) && (opc <= OPC_LDI);
  endfunction

endpackage

// File: rtl/pipelined_core_param_if.sv
// Load/debug/retirement bus of the core: master is the host, slave is the core.
interface pipelined_core_param_if import pp_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int NREGS      = 4,
  parameter int IMEM_DEPTH = 16
);
  localparam int RA = calc_ra(NREGS);
  localparam int PA = calc_ra(IMEM_DEPTH);
  localparam int IW = calc_instr_w(RA);

  logic              en;
  logic              imem_we;
  logic [PA-1:0]     imem_waddr;
  logic [IW-1:0]     imem_wdata;
  logic [RA-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [PA-1:0]     pc;
  logic              wb_valid;
  logic [RA-1:0]     wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              halted;

  modport master (
    output en, imem_we, imem_waddr, imem_wdata, dbg_addr,
    input  dbg_data, pc, wb_valid, wb_rd, wb_data, halted
  );

  modport slave (
    input  en, imem_we, imem_waddr, imem_wdata, dbg_addr,
    output dbg_data, pc, wb_valid, wb_rd, wb_data, halted
  );
endinterface

// File: rtl/pipelined_core_param_regfile.sv
// Architectural register file: two operand read ports, one debug read port, one write port.
module pp_regfile #(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 4,
  localparam int RA     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [RA-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA-1:0]     raddr_a,
  input  logic [RA-1:0]     raddr_b,
  input  logic [RA-1:0]     dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] regs_r [NREGS];

  // register storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs_r[raddr_a];
  assign rdata_b  = regs_r[raddr_b];
  assign dbg_data = regs_r[dbg_addr];
endmodule

// File: rtl/pipelined_core_param.sv
// In-order IF/ID/EX/WB integer core with full forwarding, HALT and global enable.
// No stalls: operands are resolved at ID from EX, then EX_WB, then the register file.
module pipelined_core_param import pp_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int NREGS      = 4,
  parameter int IMEM_DEPTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipelined_core_param_if.slave  bus
);
  localparam int RA = calc_ra(NREGS);
  localparam int PA = calc_ra(IMEM_DEPTH);
  localparam int IW = calc_instr_w(RA);

  logic [IW-1:0]     imem_r [IMEM_DEPTH];
  logic [PA-1:0]     pc_r;
  logic              fetch_stop_r;
  logic              if_id_valid_r;
  logic [IW-1:0]     if_id_instr_r;
  logic              id_ex_valid_r;
  logic [2:0]        id_ex_opc_r;
  logic [RA-1:0]     id_ex_rd_r;
  logic [DATA_W-1:0] id_ex_a_r, id_ex_b_r;
  logic              wb_valid_r, wb_halt_r, halted_r;
  logic [RA-1:0]     wb_rd_r;
  logic [DATA_W-1:0] wb_data_r;

  logic [2:0]        opc_s;
  logic [RA-1:0]     rd_s, rs_s, rt_s;
  logic [DATA_W-1:0] imm_s, rf_a_s, rf_b_s, op_a_s, op_b_s, alu_s;
  logic              ex_fwd_ok_s;

  // instruction memory load path, live even while the core is in reset
  always_ff @(posedge clk) begin
    if (bus.imem_we) imem_r[bus.imem_waddr] <= bus.imem_wdata;
  end

  assign opc_s = get_opc(32'(if_id_instr_r), RA);
  assign rd_s  = RA'(get_field(32'(if_id_instr_r), RA, 32'sd2));
  assign rs_s  = RA'(get_field(32'(if_id_instr_r), RA, 32'sd1));
  assign rt_s  = RA'(get_field(32'(if_id_instr_r), RA, 32'sd0));
  assign imm_s = DATA_W'(get_imm(32'(if_id_instr_r), RA));
  assign ex_fwd_ok_s = id_ex_valid_r && is_writer(id_ex_opc_r);

  pp_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst),
    .we       (bus.en && wb_valid_r),
    .waddr    (wb_rd_r),
    .wdata    (wb_data_r),
    .raddr_a  (rs_s),
    .raddr_b  (rt_s),
    .dbg_addr (bus.dbg_addr),
    .rdata_a  (rf_a_s),
    .rdata_b  (rf_b_s),
    .dbg_data (bus.dbg_data)
  );

  // operand forwarding: youngest producer wins
  always_comb begin
    op_a_s = rf_a_s;
    op_b_s = rf_b_s;
    if (ex_fwd_ok_s && id_ex_rd_r == rs_s) op_a_s = alu_s;
    else if (wb_valid_r && wb_rd_r == rs_s) op_a_s = wb_data_r;
    else op_a_s = rf_a_s;
    if (ex_fwd_ok_s && id_ex_rd_r == rt_s) op_b_s = alu_s;
    else if (wb_valid_r && wb_rd_r == rt_s) op_b_s = wb_data_r;
    else op_b_s = rf_b_s;
  end

  // EX-stage ALU; LDI carries its immediate in operand a
  always_comb begin
    alu_s = '0;
    case (id_ex_opc_r)
      OPC_ADD:           alu_s = id_ex_a_r + id_ex_b_r;
      OPC_SUB:           alu_s = id_ex_a_r - id_ex_b_r;
      OPC_AND:           alu_s = id_ex_a_r & id_ex_b_r;
      OPC_OR:            alu_s = id_ex_a_r | id_ex_b_r;
      OPC_XOR:           alu_s = id_ex_a_r ^ id_ex_b_r;
      OPC_LDI:           alu_s = id_ex_a_r;
      OPC_NOP, OPC_HALT: alu_s = '0;
      default:           alu_s = '0;
    endcase
  end

  // pipeline registers, pc and halt tracking; everything holds while en is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r          <= '0;
      fetch_stop_r  <= 1'b0;
      if_id_valid_r <= 1'b0;
      if_id_instr_r <= '0;
      id_ex_valid_r <= 1'b0;
      id_ex_opc_r   <= OPC_NOP;
      id_ex_rd_r    <= '0;
      id_ex_a_r     <= '0;
      id_ex_b_r     <= '0;
      wb_valid_r    <= 1'b0;
      wb_halt_r     <= 1'b0;
      wb_rd_r       <= '0;
      wb_data_r     <= '0;
      halted_r      <= 1'b0;
    end else if (bus.en) begin
      if (fetch_stop_r || (if_id_valid_r && opc_s == OPC_HALT)) begin
        fetch_stop_r  <= 1'b1;
        if_id_valid_r <= 1'b0;
        if_id_instr_r <= '0;
      end else begin
        if_id_valid_r <= 1'b1;
        if_id_instr_r <= imem_r[pc_r];
        pc_r          <= pc_r + PA'(1'b1);
      end
      id_ex_valid_r <= if_id_valid_r;
      id_ex_opc_r   <= if_id_valid_r ? opc_s : OPC_NOP;
      id_ex_rd_r    <= rd_s;
      id_ex_a_r     <= (opc_s == OPC_LDI) ? imm_s : op_a_s;
      id_ex_b_r     <= op_b_s;
      wb_valid_r    <= ex_fwd_ok_s;
      wb_halt_r     <= id_ex_valid_r && (id_ex_opc_r == OPC_HALT);
      wb_rd_r       <= id_ex_rd_r;
      wb_data_r     <= alu_s;
      if (wb_halt_r) halted_r <= 1'b1;
    end
  end

  assign bus.pc       = pc_r;
  assign bus.wb_valid = wb_valid_r;
  assign bus.wb_rd    = wb_rd_r;
  assign bus.wb_data  = wb_data_r;
  assign bus.halted   = halted_r;
endmodule

// File: tb/tb_pipelined_core_param.sv
// Bench for pipelined_core_param: directed scenarios plus random programs against
// a sequential-execution model that maps fetch index n to retirement at enabled edge n+4.
module tb_pipelined_core_param;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] prog [16];
  logic [7:0] m_regs [4];
  logic [3:0] m_pc;
  logic       m_halted, m_wv;
  logic [1:0] m_wrd;
  logic [7:0] m_wd;
  logic [7:0] rv;
  logic [7:0] t1_regs [4];

  always #5 clk = ~clk;

  pipelined_core_param_if #(.DATA_W(8), .NREGS(4), .IMEM_DEPTH(16)) bus ();

  pipelined_core_param #(.DATA_W(8), .NREGS(4), .IMEM_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [8:0] enc(input int opc, input int rd, input int rs, input int rt);
    return {3'(opc), 2'(rd), 2'(rs), 2'(rt)};
  endfunction

  // architectural state expected after 'edges' enabled clock edges since reset release
  function automatic void model_run(input int edges);
    logic [7:0] a [4];
    logic [2:0] opc;
    logic [1:0] rd, rs, rt;
    logic [7:0] res;
    bit wr;
    int fetched;
    for (int i = 0; i < 4; i++) begin a[i] = 8'h00; m_regs[i] = 8'h00; end
    m_halted = 1'b0; m_wv = 1'b0; m_wrd = 2'd0; m_wd = 8'h00;
    fetched = edges;
    for (int n = 0; n < edges; n++) begin
      {opc, rd, rs, rt} = prog[n % 16];
      case (opc)
        3'd1: res = a[rs] + a[rt];
        3'd2: res = a[rs] - a[rt];
        3'd3: res = a[rs] & a[rt];
        3'd4: res = a[rs] | a[rt];
        3'd5: res = a[rs] ^ a[rt];
        3'd6: res = {4'b0000, rs, rt};
        default: res = 8'h00;
      endcase
      wr = (opc >= 3'd1) && (opc <= 3'd6);
      if (n == edges - 3) begin m_wv = wr; m_wrd = rd; m_wd = res; end
      if (wr) begin
        a[rd] = res;
        if (n + 4 <= edges) m_regs[rd] = res;
      end
      if (opc == 3'd7) begin
        if (n + 4 <= edges) m_halted = 1'b1;
        fetched = n + 1;
        break;
      end
    end
    m_pc = 4'(fetched % 16);
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd_reg(input int i, output logic [7:0] v);
    bus.dbg_addr = 2'(i);
    #1;
    v = bus.dbg_data;
  endtask

  // holds reset, writes prog[] into imem through the load path, then releases
  task automatic load_prog();
    rst = 1'b0;
    bus.en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.imem_we = 1'b1; bus.imem_waddr = 4'(i); bus.imem_wdata = prog[i];
      @(posedge clk); #1;
    end
    bus.imem_we = 1'b0;
    rst = 1'b1;
  endtask

  task automatic set_test1();
    for (int i = 0; i < 16; i++) prog[i] = 9'd0;
    prog[0] = enc(6, 1, 1, 1);
    prog[1] = enc(6, 2, 0, 3);
    prog[2] = enc(1, 3, 1, 2);
    prog[3] = enc(2, 0, 2, 1);
    prog[4] = enc(7, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.imem_we = 1'b0; bus.dbg_addr = 2'd0;
    bus.imem_waddr = 4'd0; bus.imem_wdata = 9'd0;
    #1 rst = 1'b0;
    step(2);
    n_tests++; if (bus.pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d exp 0", bus.pc); end
    n_tests++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b exp 0", bus.halted); end
    n_tests++; if (bus.wb_valid !== 1'b0 || bus.wb_rd !== 2'd0 || bus.wb_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_wb: got %b/%0d/%h exp 0/0/00", bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, rv);
      n_tests++; if (rv !== 8'h00) begin n_fail++; $display("FAIL reset_r%0d: got %h exp 00", i, rv); end
    end
  endtask

  task automatic test_basic();
    set_test1(); load_prog(); bus.en = 1'b1;
    step(8);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, rv);
      n_tests++; if (rv !== t1_regs[i]) begin n_fail++; $display("FAIL basic_r%0d: got %h exp %h", i, rv, t1_regs[i]); end
    end
    n_tests++; if (bus.pc !== 4'd5) begin n_fail++; $display("FAIL basic_pc: got %0d exp 5", bus.pc); end
    n_tests++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL basic_halted: got %b exp 1", bus.halted); end
  endtask

  task automatic test_post_halt();
    set_test1(); prog[5] = enc(6, 1, 3, 3); load_prog(); bus.en = 1'b1;
    step(20);
    rd_reg(1, rv);
    n_tests++; if (rv !== 8'h05) begin n_fail++; $display("FAIL post_halt_r1: got %h exp 05", rv); end
    n_tests++; if (bus.pc !== 4'd5) begin n_fail++; $display("FAIL post_halt_pc: got %0d exp 5", bus.pc); end
    n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_halt_wb: got %b exp 0", bus.wb_valid); end
  endtask

  task automatic test_enable_freeze();
    set_test1(); load_prog(); bus.en = 1'b1;
    step(2);
    model_run(2);
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      n_tests++; if (bus.pc !== m_pc || bus.wb_valid !== m_wv) begin
        n_fail++; $display("FAIL freeze_hold: got pc %0d wbv %b exp %0d %b", bus.pc, bus.wb_valid, m_pc, m_wv);
      end
      rd_reg(1, rv);
      n_tests++; if (rv !== m_regs[1]) begin n_fail++; $display("FAIL freeze_r1: got %h exp %h", rv, m_regs[1]); end
    end
    bus.en = 1'b1;
    step(6);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, rv);
      n_tests++; if (rv !== t1_regs[i]) begin n_fail++; $display("FAIL freeze_final_r%0d: got %h exp %h", i, rv, t1_regs[i]); end
    end
    n_tests++; if (bus.pc !== 4'd5 || bus.halted !== 1'b1) begin
      n_fail++; $display("FAIL freeze_final: got pc %0d halted %b exp 5 1", bus.pc, bus.halted);
    end
  endtask

  task automatic test_pc_wrap();
    for (int i = 0; i < 16; i++) prog[i] = 9'd0;
    prog[15] = enc(6, 2, 2, 1);
    load_prog(); bus.en = 1'b1;
    step(15);
    n_tests++; if (bus.pc !== 4'd15) begin n_fail++; $display("FAIL wrap_pc15: got %0d exp 15", bus.pc); end
    step(1);
    n_tests++; if (bus.pc !== 4'd0) begin n_fail++; $display("FAIL wrap_pc0: got %0d exp 0", bus.pc); end
    step(2);
    rd_reg(2, rv);
    n_tests++; if (rv !== 8'h00) begin n_fail++; $display("FAIL wrap_r2_early: got %h exp 00", rv); end
    step(1);
    rd_reg(2, rv);
    n_tests++; if (rv !== 8'h09) begin n_fail++; $display("FAIL wrap_r2: got %h exp 09", rv); end
    n_tests++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL wrap_halted: got %b exp 0", bus.halted); end
  endtask

  task automatic test_mid_reset();
    set_test1(); load_prog(); bus.en = 1'b1;
    step(3);
    #1 rst = 1'b0;
    #1;
    n_tests++; if (bus.pc !== 4'd0 || bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL midrst_pc: got pc %0d halted %b exp 0 0", bus.pc, bus.halted);
    end
    n_tests++; if (bus.wb_valid !== 1'b0 || bus.wb_rd !== 2'd0 || bus.wb_data !== 8'h00) begin
      n_fail++; $display("FAIL midrst_wb: got %b/%0d/%h exp 0/0/00", bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    rd_reg(1, rv);
    n_tests++; if (rv !== 8'h00) begin n_fail++; $display("FAIL midrst_r1: got %h exp 00", rv); end
    #1 rst = 1'b1;
    step(8);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, rv);
      n_tests++; if (rv !== t1_regs[i]) begin n_fail++; $display("FAIL midrst_rerun_r%0d: got %h exp %h", i, rv, t1_regs[i]); end
    end
    n_tests++; if (bus.pc !== 4'd5 || bus.halted !== 1'b1) begin
      n_fail++; $display("FAIL midrst_rerun: got pc %0d halted %b exp 5 1", bus.pc, bus.halted);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 16; i++) prog[i] = 9'd0;
    prog[0] = enc(6, 1, 0, 1);
    prog[1] = enc(6, 1, 0, 2);
    prog[2] = enc(1, 2, 1, 1);
    prog[3] = enc(7, 0, 0, 0);
    load_prog(); bus.en = 1'b1;
    step(8);
    rd_reg(2, rv);
    n_tests++; if (rv !== 8'h04) begin n_fail++; $display("FAIL priority_r2: got %h exp 04", rv); end
    rd_reg(1, rv);
    n_tests++; if (rv !== 8'h02) begin n_fail++; $display("FAIL priority_r1: got %h exp 02", rv); end
  endtask

  task automatic test_same_edge_write();
    for (int i = 0; i < 16; i++) prog[i] = 9'd0;
    load_prog(); bus.en = 1'b1;
    step(2);
    bus.imem_we = 1'b1; bus.imem_waddr = 4'd2; bus.imem_wdata = enc(6, 1, 1, 3);
    step(1);
    bus.imem_we = 1'b0;
    step(7);
    rd_reg(1, rv);
    n_tests++; if (rv !== 8'h00) begin n_fail++; $display("FAIL same_edge_old_word: got %h exp 00", rv); end
    n_tests++; if (bus.pc !== 4'd10) begin n_fail++; $display("FAIL same_edge_pc: got %0d exp 10", bus.pc); end
    step(12);
    rd_reg(1, rv);
    n_tests++; if (rv !== 8'h07) begin n_fail++; $display("FAIL same_edge_new_word: got %h exp 07", rv); end
  endtask

  task automatic test_random();
    int enabled;
    logic [2:0] opc;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) begin
        opc = 3'($urandom_range(0, 6));
        if ($urandom_range(0, 24) == 0) opc = 3'd7;
        prog[i] = enc(int'(opc), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      load_prog();
      enabled = 0;
      for (int c = 0; c < 40; c++) begin
        bus.en = ($urandom_range(0, 3) != 0);
        if (bus.en) enabled++;
        step(1);
        model_run(enabled);
        n_tests++; if (bus.pc !== m_pc || bus.halted !== m_halted) begin
          n_fail++; $display("FAIL rand_ctrl p%0d c%0d: got pc %0d halted %b exp %0d %b", p, c, bus.pc, bus.halted, m_pc, m_halted);
        end
        n_tests++; if (bus.wb_valid !== m_wv || (m_wv && (bus.wb_rd !== m_wrd || bus.wb_data !== m_wd))) begin
          n_fail++; $display("FAIL rand_wb p%0d c%0d: got %b/%0d/%h exp %b/%0d/%h", p, c, bus.wb_valid, bus.wb_rd, bus.wb_data, m_wv, m_wrd, m_wd);
        end
        for (int i = 0; i < 4; i++) begin
          rd_reg(i, rv);
          n_tests++; if (rv !== m_regs[i]) begin n_fail++; $display("FAIL rand_r%0d p%0d c%0d: got %h exp %h", i, p, c, rv, m_regs[i]); end
        end
      end
    end
  endtask

  initial begin
    t1_regs = '{8'hFE, 8'h05, 8'h03, 8'h08};
    test_reset();
    test_basic();
    test_post_halt();
    test_enable_freeze();
    test_pc_wrap();
    test_mid_reset();
    test_priority();
    test_same_edge_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
